// File: rtl/ones_sub_pkg.sv
// Shared definitions for the ones'-complement subtract arbiter.
// Holds the default operand width, requester count, FSM state type and a
// single-bit full-adder helper used by the arithmetic unit.
package ones_sub_pkg;

  localparam int ONES_SUB_WIDTH = 4;
  localparam int ONES_SUB_NREQ  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // Returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic cin);
    full_add = {(x & y) | (x & cin) | (y & cin), x ^ y ^ cin};
  endfunction

endpackage

// File: rtl/ones_sub_arbiter_if.sv
// Request/result bundle for ones_sub_arbiter.
// Ports: req_valid/req_ready per requester, two operand pairs, and a
//   valid/ready result channel carrying data, owner id and negative-zero flag.
interface ones_sub_arbiter_if
  import ones_sub_pkg::*;
#(
  parameter int WIDTH = ONES_SUB_WIDTH
);

  logic [ONES_SUB_NREQ-1:0] req_valid;
  logic [ONES_SUB_NREQ-1:0] req_ready;
  logic [WIDTH-1:0]         req_a0;
  logic [WIDTH-1:0]         req_b0;
  logic [WIDTH-1:0]         req_a1;
  logic [WIDTH-1:0]         req_b1;
  logic                     res_valid;
  logic                     res_ready;
  logic [WIDTH-1:0]         res_data;
  logic                     res_id;
  logic                     res_negzero;

  // Requesters and result consumer.
  modport master (
    output req_valid, req_a0, req_b0, req_a1, req_b1, res_ready,
    input  req_ready, res_valid, res_data, res_id, res_negzero
  );

  // The arbiter itself.
  modport slave (
    input  req_valid, req_a0, req_b0, req_a1, req_b1, res_ready,
    output req_ready, res_valid, res_data, res_id, res_negzero
  );

endinterface

// File: rtl/ones_sub_unit.sv
// Ones'-complement subtractor Y = A - B, purely combinational.
// Ports: a_i minuend, b_i subtrahend, y_o difference, negzero_o when y_o is all-ones.
// No state, no backpressure; result valid in the same cycle as the operands.
module ones_sub_unit
  import ones_sub_pkg::*;
#(
  parameter int WIDTH = ONES_SUB_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o,
  output logic             negzero_o
);

  logic [WIDTH-1:0] sum1;
  logic [WIDTH-1:0] sum2;
  logic             carry;
  logic             end_carry;
  logic [1:0]       fa;

  always_comb begin
    sum1      = '0;
    sum2      = '0;
    carry     = 1'b0;
    end_carry = 1'b0;
    fa        = '0;
    // First ripple pass: A + ~B with no carry in.
    for (int i = 0; i < WIDTH; i++) begin
      fa      = full_add(a_i[i], ~b_i[i], carry);
      sum1[i] = fa[0];
      carry   = fa[1];
    end
    end_carry = carry;
    // Second ripple pass folds the end-around carry back into bit 0. It can
    // never overflow, so its final carry is dropped.
    carry = end_carry;
    for (int i = 0; i < WIDTH; i++) begin
      fa      = full_add(sum1[i], 1'b0, carry);
      sum2[i] = fa[0];
      carry   = fa[1];
    end
  end

  assign y_o       = sum2;
  // A == B yields negative zero; it is deliberately left un-normalised.
  assign negzero_o = &sum2;

endmodule

// File: rtl/ones_sub_arbiter.sv
// Two-requester round-robin front end to a ones'-complement subtractor.
// Ports: clk, rst_n (async active-low), bus (slave side of ones_sub_arbiter_if).
// Latency: request handshake -> result valid two cycles later; at most one op per 3 cycles.
// Backpressure: result held stable until res_ready; no request accepted outside IDLE.
module ones_sub_arbiter
  import ones_sub_pkg::*;
#(
  parameter int WIDTH = ONES_SUB_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  ones_sub_arbiter_if.slave  bus
);

  state_e                   state_q, state_d;
  logic [WIDTH-1:0]         a_q, b_q;
  logic                     id_q;
  logic                     last_grant_q;
  logic [WIDTH-1:0]         res_data_q;
  logic                     res_id_q;
  logic                     res_negzero_q;
  logic                     res_valid_q;

  logic                     grant_vld;
  logic                     grant_id;
  logic                     req_hs;
  logic [ONES_SUB_NREQ-1:0] req_ready;
  logic [WIDTH-1:0]         diff;
  logic                     diff_negzero;

  ones_sub_unit #(.WIDTH(WIDTH)) u_unit (
    .a_i       (a_q),
    .b_i       (b_q),
    .y_o       (diff),
    .negzero_o (diff_negzero)
  );

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    case (bus.req_valid)
      2'b01: begin grant_vld = 1'b1; grant_id = 1'b0;          end
      2'b10: begin grant_vld = 1'b1; grant_id = 1'b1;          end
      2'b11: begin grant_vld = 1'b1; grant_id = ~last_grant_q; end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    req_hs    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // ready is only raised toward a requester that is already valid, so
        // raising it is the handshake.
        if (grant_vld) begin
          req_ready = grant_id ? 2'b10 : 2'b01;
          req_hs    = 1'b1;
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: state_d = ST_HOLD;
      ST_HOLD: if (bus.res_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      a_q           <= '0;
      b_q           <= '0;
      id_q          <= 1'b0;
      last_grant_q  <= 1'b1;   // requester 0 wins the first tie
      res_data_q    <= '0;
      res_id_q      <= 1'b0;
      res_negzero_q <= 1'b0;
      res_valid_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (req_hs) begin
        a_q          <= grant_id ? bus.req_a1 : bus.req_a0;
        b_q          <= grant_id ? bus.req_b1 : bus.req_b0;
        id_q         <= grant_id;
        last_grant_q <= grant_id;
      end
      if (state_q == ST_EXEC) begin
        res_data_q    <= diff;
        res_id_q      <= id_q;
        res_negzero_q <= diff_negzero;
        res_valid_q   <= 1'b1;
      end
      if ((state_q == ST_HOLD) && bus.res_ready) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  assign bus.req_ready   = req_ready;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_data    = res_data_q;
  assign bus.res_id      = res_id_q;
  assign bus.res_negzero = res_negzero_q;

endmodule
